// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the FIFO-drain UART transmitter and its
// companion parity logic.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    localparam logic ParEven = 1'b0;
    localparam logic ParOdd  = 1'b1;

    // Bits needed for a counter holding 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        if (n > 1) begin
            w = int'($clog2(n));
        end
        return w;
    endfunction

endpackage

// File: rtl/parity_calc.sv
// Combinational parity generator: returns the bit that makes the frame's
// count of ones even (ParEven) or odd (ParOdd).
module parity_calc
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  par_bit_o
);

    always_comb begin
        par_bit_o = ^data_i;
        unique case (par_typ_i)
            ParEven: par_bit_o = ^data_i;
            ParOdd:  par_bit_o = ~^data_i;
        endcase
    end

endmodule

// File: rtl/fifo_rd_uart_tx.sv
// FIFO read-side consumer: pops one word whenever the line is idle and the
// FIFO is non-empty, then shifts it out as start / data LSB-first / parity / stop.
module fifo_rd_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EMPTY,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  R_INC,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  FRAME_DONE
);

    localparam int unsigned CntW = cnt_width(CLKS_PER_BIT);
    localparam int unsigned BitW = int'($clog2(DATA_WIDTH)) + 1;

    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(DATA_WIDTH - 1);

    tx_state_e             state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic                  pop;
    logic                  bit_end;
    logic                  par_calc;
    logic                  frame_done;

    parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_calc (
        .data_i    (RD_DATA),
        .par_typ_i (PAR_TYP),
        .par_bit_o (par_calc)
    );

    // Gated by RST so the pop strobe drops the instant reset is applied.
    assign pop     = ~RST & (state_q == StIdle) & ~EMPTY;
    assign bit_end = (cnt_q == CntLast);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        tx_d       = tx_q;
        frame_done = 1'b0;

        if (state_q != StIdle) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        // tx_d is the line level for the state being entered, so TX_OUT changes
        // on the same edge as the state register.
        unique case (state_q)
            StIdle: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                bit_d = '0;
                if (pop) begin
                    shift_d   = RD_DATA;
                    par_en_d  = PAR_EN;
                    par_bit_d = par_calc;
                    tx_d      = 1'b0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_q == BitLast) begin
                        bit_d = '0;
                        if (par_en_q) begin
                            tx_d    = par_bit_q;
                            state_d = StParity;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = StStop;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = StStop;
                end
            end
            StStop: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    frame_done = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
        end
    end

    assign R_INC      = pop;
    assign TX_OUT     = tx_q;
    assign BUSY       = (state_q != StIdle);
    assign FRAME_DONE = frame_done;

endmodule

// File: tb/tb_fifo_rd_uart_tx.sv
// Self-checking bench: a FIFO model feeds the DUT and a per-cycle line
// timeline built from the frame format predicts TX_OUT, BUSY, FRAME_DONE, R_INC.
module tb_fifo_rd_uart_tx;

    localparam int W = 8;
    localparam int C = 4;

    logic         CLK;
    logic         RST;
    logic         EMPTY;
    logic [W-1:0] RD_DATA;
    logic         PAR_EN;
    logic         PAR_TYP;
    logic         R_INC;
    logic         TX_OUT;
    logic         BUSY;
    logic         FRAME_DONE;

    fifo_rd_uart_tx #(
        .DATA_WIDTH   (W),
        .CLKS_PER_BIT (C)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EMPTY      (EMPTY),
        .RD_DATA    (RD_DATA),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .R_INC      (R_INC),
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY),
        .FRAME_DONE (FRAME_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks;
    int n_errors;
    int cyc;
    int pop_cyc;
    int last_len;
    int dut_pops;
    int prev_rinc_cyc;
    int last_gap;

    logic [W-1:0] fifo_q[$];
    logic         exp_line[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic refresh();
        EMPTY   = (fifo_q.size() == 0);
        RD_DATA = EMPTY ? '0 : fifo_q[0];
    endtask

    task automatic push(input logic [W-1:0] w);
        fifo_q.push_back(w);
        refresh();
    endtask

    // Expected line level for every cycle of one frame, from the frame format.
    task automatic schedule(input logic [W-1:0] w);
        logic b;
        repeat (C) exp_line.push_back(1'b0);
        for (int i = 0; i < W; i++) begin
            repeat (C) exp_line.push_back(w[i]);
        end
        if (PAR_EN) begin
            b = (($countones(w) % 2) == 1) ^ PAR_TYP;
            repeat (C) exp_line.push_back(b);
        end
        repeat (C) exp_line.push_back(1'b1);
        last_len = (2 + W + (PAR_EN ? 1 : 0)) * C;
    endtask

    task automatic tick();
        logic tx_e, busy_e, done_e, rinc_e;
        @(negedge CLK);
        cyc++;
        if (exp_line.size() > 0) begin
            tx_e   = exp_line.pop_front();
            busy_e = 1'b1;
            done_e = (exp_line.size() == 0);
        end else begin
            tx_e   = 1'b1;
            busy_e = 1'b0;
            done_e = 1'b0;
        end
        rinc_e = !RST && !busy_e && (fifo_q.size() > 0);
        check_eq("tx_out", TX_OUT, tx_e);
        check_eq("busy", BUSY, busy_e);
        check_eq("frame_done", FRAME_DONE, done_e);
        check_eq("r_inc", R_INC, rinc_e);
        if (FRAME_DONE) check_eq("frame_len", cyc - pop_cyc, last_len);
        if (R_INC) begin
            dut_pops++;
            last_gap      = cyc - prev_rinc_cyc;
            prev_rinc_cyc = cyc;
        end
        if (rinc_e) begin
            schedule(fifo_q[0]);
            pop_cyc = cyc;
        end
        @(posedge CLK);
        #1;
        if (rinc_e) void'(fifo_q.pop_front());
        refresh();
    endtask

    task automatic run_idle(input int budget);
        int k;
        k = 0;
        while ((exp_line.size() > 0 || fifo_q.size() > 0) && k < budget) begin
            tick();
            k++;
        end
        check_eq("idle_reached", k < budget, 1);
        tick();
        tick();
    endtask

    task automatic wait_pop(input int budget);
        int k;
        int p;
        k = 0;
        p = dut_pops;
        while (dut_pops == p && k < budget) begin
            tick();
            k++;
        end
        check_eq("pop_seen", dut_pops != p, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tx"}, TX_OUT, 1'b1);
        check_eq({tag, "_busy"}, BUSY, 1'b0);
        check_eq({tag, "_rinc"}, R_INC, 1'b0);
        check_eq({tag, "_done"}, FRAME_DONE, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int n;
        n_checks      = 0;
        n_errors      = 0;
        cyc           = 0;
        pop_cyc       = 0;
        last_len      = 0;
        dut_pops      = 0;
        prev_rinc_cyc = 0;
        last_gap      = 0;
        RST     = 1'b1;
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        refresh();
        #1;
        check_reset_outputs("reset");
        tick();
        tick();
        RST = 1'b0;
        tick();

        // Basic even-parity frame
        PAR_EN  = 1'b1;
        PAR_TYP = 1'b0;
        p0 = dut_pops;
        push(8'hA5);
        run_idle(200);
        check_eq("basic_pops", dut_pops - p0, 1);
        check_eq("basic_len", last_len, 44);

        // Odd parity, both parity outcomes
        PAR_TYP = 1'b1;
        push(8'h07);
        run_idle(200);
        push(8'h03);
        run_idle(200);

        // No parity
        PAR_EN = 1'b0;
        p0 = dut_pops;
        push(8'hFF);
        run_idle(200);
        check_eq("nopar_pops", dut_pops - p0, 1);

        // Back-to-back
        p0 = dut_pops;
        push(8'h01);
        push(8'h80);
        run_idle(300);
        check_eq("b2b_pops", dut_pops - p0, 2);
        check_eq("b2b_spacing", last_gap, 41);

        // Empty FIFO
        p0 = dut_pops;
        repeat (100) tick();
        check_eq("empty_pops", dut_pops - p0, 0);

        // Reset during the third data bit
        PAR_EN  = 1'b1;
        PAR_TYP = 1'b0;
        p0 = dut_pops;
        push(8'h55);
        push(8'h3C);
        wait_pop(50);
        repeat (13) tick();
        RST = 1'b1;
        exp_line.delete();
        #1;
        check_reset_outputs("midreset");
        tick();
        tick();
        RST = 1'b0;
        run_idle(200);
        check_eq("midreset_pops", dut_pops - p0, 2);
        check_eq("midreset_fifo", fifo_q.size(), 0);

        // Randomized traffic with parity settings changing mid-frame
        for (int i = 0; i < 25; i++) begin
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) push(W'($urandom));
            PAR_EN  = 1'($urandom_range(0, 1));
            PAR_TYP = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 60)) begin
                tick();
                if ($urandom_range(0, 7) == 0) begin
                    PAR_EN  = 1'($urandom_range(0, 1));
                    PAR_TYP = 1'($urandom_range(0, 1));
                end
            end
        end
        run_idle(3000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
